// File: rtl/weight_bank_if.sv
// Command, direct-write, stream and readback signals of the weight bank loader.
interface weight_bank_if #(
  parameter int unsigned CH = 10,
  parameter int unsigned DW = 10,
  parameter int unsigned AW = 7
);
  logic [1:0]       cmd;
  logic             start;
  logic             we;
  logic [3:0]       ch_sel;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [AW-1:0]    rd_addr;
  logic [CH*DW-1:0] q;
  logic             busy;
  logic             done;

  modport master (
    output cmd, start, we, ch_sel, addr, wr_data, wr_valid, rd_addr,
    input  wr_ready, q, busy, done
  );

  modport slave (
    input  cmd, start, we, ch_sel, addr, wr_data, wr_valid, rd_addr,
    output wr_ready, q, busy, done
  );
endinterface

// File: rtl/weight_bank_loader.sv
// Multi-channel weight memory with a load controller (random init, clear,
// streamed download, direct write) and a registered all-channel read port.
module weight_bank_loader #(
  parameter int unsigned CH   = 10,
  parameter int unsigned DW   = 10,
  parameter int unsigned AW   = 7,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  weight_bank_if.slave bus
);

  localparam int unsigned DEPTH     = 1 << AW;
  localparam int unsigned CW        = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAND  = 2'd1,
    LOAD  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    ch_cnt;
  logic [AW-1:0]    addr_cnt;
  logic [15:0]      lfsr;
  logic [CH*DW-1:0] q_r;
  logic             busy_r;
  logic             done_r;
  logic             ready_r;

  logic [DW-1:0]    mem [CH][DEPTH];

  logic             wr_en_c;
  logic [CW-1:0]    wr_ch_c;
  logic [AW-1:0]    wr_addr_c;
  logic [DW-1:0]    wr_dat_c;
  logic             step_c;
  logic             last_c;
  logic [15:0]      lfsr_next_c;

  // Single write port: direct write in IDLE, sweep writes otherwise.
  always_comb begin
    wr_en_c   = 1'b0;
    wr_ch_c   = ch_cnt;
    wr_addr_c = addr_cnt;
    wr_dat_c  = '0;
    case (state)
      IDLE: begin
        if (!bus.start && bus.we && (32'(bus.ch_sel) < CH)) begin
          wr_en_c   = 1'b1;
          wr_ch_c   = CW'(bus.ch_sel);
          wr_addr_c = bus.addr;
          wr_dat_c  = bus.wr_data;
        end
      end
      RAND: begin
        wr_en_c  = 1'b1;
        wr_dat_c = lfsr[DW-1:0];
      end
      LOAD: begin
        wr_en_c  = bus.wr_valid && ready_r;
        wr_dat_c = bus.wr_data;
      end
      CLEAR: begin
        wr_en_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign step_c      = wr_en_c && (state != IDLE);
  assign last_c      = (32'(ch_cnt) == CH - 1) && (addr_cnt == '1);
  assign lfsr_next_c = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);

  // Command FSM with sweep counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ch_cnt   <= '0;
      addr_cnt <= '0;
      lfsr     <= SEED;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ready_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            ch_cnt   <= '0;
            addr_cnt <= '0;
            case (bus.cmd)
              2'b01: begin
                state  <= RAND;
                busy_r <= 1'b1;
                lfsr   <= SEED;
              end
              2'b10: begin
                state   <= LOAD;
                busy_r  <= 1'b1;
                ready_r <= 1'b1;
              end
              2'b11: begin
                state  <= CLEAR;
                busy_r <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        default: begin
          if (step_c) begin
            if (state == RAND) begin
              lfsr <= lfsr_next_c;
            end
            if (last_c) begin
              state    <= IDLE;
              busy_r   <= 1'b0;
              ready_r  <= 1'b0;
              done_r   <= 1'b1;
              ch_cnt   <= '0;
              addr_cnt <= '0;
            end else if (addr_cnt == '1) begin
              addr_cnt <= '0;
              ch_cnt   <= ch_cnt + CW'(1);
            end else begin
              addr_cnt <= addr_cnt + AW'(1);
            end
          end
        end
      endcase
    end
  end

  // Weight storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ch_c][wr_addr_c] <= wr_dat_c;
    end
  end

  // Read register returns pre-write data on a same-cycle collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= '0;
    end else begin
      for (int c = 0; c < int'(CH); c++) begin
        q_r[c*DW +: DW] <= mem[c][bus.rd_addr];
      end
    end
  end

  assign bus.q        = q_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.wr_ready = ready_r;

endmodule

// File: tb/tb_weight_bank_loader.sv
// Randomized bench for weight_bank_loader against a word-level memory model.
`timescale 1ns/1ps
module tb_weight_bank_loader;

  localparam int CH    = 10;
  localparam int DW    = 10;
  localparam int AW    = 7;
  localparam int DEPTH = 1 << AW;
  localparam int N     = CH * DEPTH;
  localparam int QW    = CH * DW;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  weight_bank_if #(.CH(CH), .DW(DW), .AW(AW)) bus();

  weight_bank_loader #(.CH(CH), .DW(DW), .AW(AW), .SEED(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: flat word memory + command progress ----
  typedef enum int {M_IDLE, M_RAND, M_LOAD, M_CLEAR} mode_t;

  logic [DW-1:0] mm    [CH][DEPTH];
  bit            known [CH][DEPTH];
  mode_t         mode      = M_IDLE;
  int            idx       = 0;
  logic [15:0]   lf        = SEED;
  logic          exp_busy  = 1'b0;
  logic          exp_done  = 1'b0;
  logic          exp_ready = 1'b0;
  logic [QW-1:0] exp_q     = '0;
  logic [QW-1:0] exp_mask  = '1;
  logic [QW-1:0] nq, nm;
  bit            chk_en    = 1'b0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  function automatic void put(input int c, input int a, input logic [DW-1:0] d);
    mm[c][a]    = d;
    known[c][a] = 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mode      = M_IDLE;
      exp_busy  = 1'b0;
      exp_done  = 1'b0;
      exp_ready = 1'b0;
      exp_q     = '0;
      exp_mask  = '1;
    end else begin
      for (int c = 0; c < CH; c++) begin
        nq[c*DW +: DW] = mm[c][bus.rd_addr];
        nm[c*DW +: DW] = {DW{known[c][bus.rd_addr]}};
      end
      exp_done = 1'b0;
      case (mode)
        M_IDLE: begin
          if (bus.start) begin
            idx = 0;
            case (bus.cmd)
              2'b01: begin mode = M_RAND; lf = SEED; end
              2'b10: mode = M_LOAD;
              2'b11: mode = M_CLEAR;
              default: ;
            endcase
          end else if (bus.we && int'(bus.ch_sel) < CH) begin
            put(int'(bus.ch_sel), int'(bus.addr), bus.wr_data);
          end
        end
        M_RAND: begin
          put(idx / DEPTH, idx % DEPTH, lf[DW-1:0]);
          lf = lfsr_step(lf);
          idx++;
        end
        M_CLEAR: begin
          put(idx / DEPTH, idx % DEPTH, '0);
          idx++;
        end
        M_LOAD: begin
          if (bus.wr_valid) begin
            put(idx / DEPTH, idx % DEPTH, bus.wr_data);
            idx++;
          end
        end
        default: ;
      endcase
      if (mode != M_IDLE && idx == N) begin
        mode     = M_IDLE;
        exp_done = 1'b1;
      end
      exp_busy  = (mode != M_IDLE);
      exp_ready = (mode == M_LOAD);
      exp_q     = nq;
      exp_mask  = nm;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",     QW'(bus.busy),     QW'(exp_busy));
      check("done",     QW'(bus.done),     QW'(exp_done));
      check("wr_ready", QW'(bus.wr_ready), QW'(exp_ready));
      check("q",        bus.q & exp_mask,  exp_q & exp_mask);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    bus.cmd      = 2'b00;
    bus.start    = 1'b0;
    bus.we       = 1'b0;
    bus.ch_sel   = 4'd0;
    bus.addr     = '0;
    bus.wr_data  = '0;
    bus.wr_valid = 1'b0;
  endtask

  task automatic run_sweep(input logic [1:0] cmd, input bit poke, input string tag);
    int cyc      = 0;
    int busy_cyc = 0;
    bit got      = 1'b0;
    @(negedge clk);
    bus.cmd   = cmd;
    bus.start = 1'b1;
    while (cyc < N + 50) begin
      @(negedge clk);
      cyc++;
      bus.start   = 1'b0;
      bus.we      = 1'b0;
      bus.rd_addr = AW'($urandom);
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (poke && cyc == 10) begin
        bus.start   = 1'b1;
        bus.cmd     = 2'b11;
        bus.we      = 1'b1;
        bus.ch_sel  = 4'd3;
        bus.addr    = AW'(7);
        bus.wr_data = DW'(10'h155);
      end
    end
    check({tag, " done seen"},   QW'(got),      QW'(1));
    check({tag, " done cycle"},  QW'(cyc),      QW'(N + 1));
    check({tag, " busy cycles"}, QW'(busy_cyc), QW'(N));
    idle_inputs();
  endtask

  task automatic run_load();
    int cyc     = 0;
    int hs      = 0;
    int last_hs = 0;
    bit got     = 1'b0;
    @(negedge clk);
    bus.cmd   = 2'b10;
    bus.start = 1'b1;
    while (cyc < 6 * N) begin
      @(negedge clk);
      cyc++;
      bus.start    = 1'b0;
      bus.wr_valid = 1'b0;
      bus.wr_data  = DW'($urandom);
      bus.rd_addr  = AW'($urandom);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (bus.wr_ready && hs < N && $urandom_range(99) < 40) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = DW'(hs);
        hs++;
        last_hs = cyc;
      end
    end
    check("load done seen",  QW'(got), QW'(1));
    check("load handshakes", QW'(hs),  QW'(N));
    check("load done cycle", QW'(cyc), QW'(last_hs + 1));
    idle_inputs();
  endtask

  task automatic read_at(input int a);
    @(negedge clk);
    bus.rd_addr = AW'(a);
    @(negedge clk);
  endtask

  logic [QW-1:0] v;
  int            done_seen;

  initial begin
    idle_inputs();
    bus.rd_addr = '0;

    // Reset state while rst is held across clock edges.
    repeat (3) @(negedge clk);
    check("reset busy",     QW'(bus.busy),     '0);
    check("reset done",     QW'(bus.done),     '0);
    check("reset wr_ready", QW'(bus.wr_ready), '0);
    check("reset q",        bus.q,             '0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Clear and confirm every address reads zero.
    run_sweep(2'b11, 1'b0, "clear");
    for (int a = 0; a < DEPTH; a++) begin
      read_at(a);
      check("clear readback", bus.q, '0);
    end

    // Direct write: old data on the first read, new data two cycles after We.
    @(negedge clk);
    bus.we = 1'b1; bus.ch_sel = 4'd3; bus.addr = AW'(7); bus.wr_data = DW'(10'h2AA);
    bus.rd_addr = AW'(7);
    @(negedge clk);
    bus.we = 1'b0;
    check("direct write old data", bus.q, '0);
    @(negedge clk);
    v = '0;
    v[39:30] = 10'h2AA;
    check("direct write new data", bus.q, v);

    // Out-of-range channel is dropped.
    bus.we = 1'b1; bus.ch_sel = 4'd12; bus.wr_data = DW'(10'h3FF);
    @(negedge clk);
    bus.we = 1'b0;
    repeat (2) @(negedge clk);
    check("ch_sel 12 dropped", bus.q, v);

    // Start with Cmd 00 together with We: no command, write dropped.
    bus.cmd = 2'b00; bus.start = 1'b1; bus.we = 1'b1; bus.ch_sel = 4'd3;
    bus.wr_data = DW'(10'h155);
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    check("start+we dropped", bus.q, v);
    check("cmd 00 not busy",  QW'(bus.busy), '0);

    // Random init with a Start/We poke mid-command.
    run_sweep(2'b01, 1'b1, "rand");
    repeat (5) @(negedge clk);
    read_at(0);
    check("rand ch0 a0", QW'(bus.q[DW-1:0]), QW'(10'h0E1));
    read_at(1);
    check("rand ch0 a1", QW'(bus.q[DW-1:0]), QW'(10'h270));
    for (int a = 0; a < DEPTH; a++) read_at(a);

    // Stream load, then check the index pattern everywhere.
    run_load();
    for (int a = 0; a < DEPTH; a++) begin
      read_at(a);
      for (int c = 0; c < CH; c++) v[c*DW +: DW] = DW'(c * DEPTH + a);
      check("load readback", bus.q, v);
    end

    // Reset in the middle of a stream load.
    @(negedge clk);
    bus.cmd = 2'b10; bus.start = 1'b1;
    repeat (60) begin
      @(negedge clk);
      bus.start    = 1'b0;
      bus.wr_valid = ($urandom_range(1) == 1);
      bus.wr_data  = DW'($urandom);
      bus.rd_addr  = AW'($urandom_range(DEPTH - 1));
    end
    #2 rst = 1'b1;
    #1;
    check("abort busy",     QW'(bus.busy),     '0);
    check("abort done",     QW'(bus.done),     '0);
    check("abort wr_ready", QW'(bus.wr_ready), '0);
    check("abort q",        bus.q,             '0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      bus.rd_addr = AW'($urandom);
      if (bus.done) done_seen++;
    end
    check("no done after abort", QW'(done_seen), '0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
